// File: rtl/serializer_stream.sv
// Parallel-to-serial converter with configurable bit period, bit order, optional
// start/stop framing and a one-word holding buffer for gap-free back-to-back frames.
module serializer_stream #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter bit MSB_FIRST    = 1'b1,
    parameter bit FRAMED       = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  start,
    output logic                  ready,
    output logic                  busy,
    output logic                  data_out,
    output logic                  frame_done
);

    localparam int FRAME_BITS = DATA_WIDTH + (FRAMED ? 2 : 0);
    localparam int CW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW         = $clog2(FRAME_BITS + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_WIDTH - 1);
    localparam logic          IDLE_LEVEL = FRAMED;

    typedef enum logic [1:0] {
        IDLE,
        START_BIT,
        DATA,
        STOP_BIT
    } state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] shift_q, shift_nxt;
    logic [DATA_WIDTH-1:0] hold_q, hold_nxt;
    logic                  hold_valid, hold_valid_nxt;
    logic [CW-1:0]         clk_cnt, clk_cnt_nxt;
    logic [BW-1:0]         bit_cnt, bit_cnt_nxt;
    logic                  data_out_nxt, frame_done_nxt;
    logic                  accept, bit_end, frame_end;

    // The bit currently on the line always sits at the head of the shift register.
    function automatic logic head_bit(input logic [DATA_WIDTH-1:0] w);
        return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w);
        return MSB_FIRST ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
    endfunction

    assign ready   = !hold_valid;
    assign busy    = (state != IDLE);
    assign accept  = start && ready;
    assign bit_end = (clk_cnt == CNT_LAST);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_nxt      = state;
        shift_nxt      = shift_q;
        hold_nxt       = hold_q;
        hold_valid_nxt = hold_valid;
        clk_cnt_nxt    = clk_cnt;
        bit_cnt_nxt    = bit_cnt;
        frame_done_nxt = 1'b0;
        frame_end      = 1'b0;
        data_out_nxt   = IDLE_LEVEL;

        case (state)
            IDLE: ;
            START_BIT: begin
                if (bit_end) begin
                    state_nxt   = DATA;
                    clk_cnt_nxt = '0;
                end else begin
                    clk_cnt_nxt = clk_cnt + 1'b1;
                end
            end
            DATA: begin
                if (!bit_end) begin
                    clk_cnt_nxt = clk_cnt + 1'b1;
                end else begin
                    clk_cnt_nxt = '0;
                    if (bit_cnt == BIT_LAST) begin
                        if (FRAMED) state_nxt = STOP_BIT;
                        else        frame_end = 1'b1;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                        shift_nxt   = advance(shift_q);
                    end
                end
            end
            STOP_BIT: begin
                if (bit_end) frame_end   = 1'b1;
                else         clk_cnt_nxt = clk_cnt + 1'b1;
            end
            default: state_nxt = IDLE;
        endcase

        if (frame_end) begin
            frame_done_nxt = 1'b1;
            state_nxt      = IDLE;
        end

        // A waiting word (held, or arriving on the closing edge) starts the next frame with no gap.
        if (frame_end && hold_valid) begin
            shift_nxt      = hold_q;
            hold_valid_nxt = 1'b0;
            clk_cnt_nxt    = '0;
            bit_cnt_nxt    = '0;
            state_nxt      = FRAMED ? START_BIT : DATA;
        end else if (accept && (state == IDLE || frame_end)) begin
            shift_nxt   = data_in;
            clk_cnt_nxt = '0;
            bit_cnt_nxt = '0;
            state_nxt   = FRAMED ? START_BIT : DATA;
        end else if (accept) begin
            hold_nxt       = data_in;
            hold_valid_nxt = 1'b1;
        end

        case (state_nxt)
            START_BIT: data_out_nxt = 1'b0;
            DATA:      data_out_nxt = head_bit(shift_nxt);
            STOP_BIT:  data_out_nxt = 1'b1;
            default:   data_out_nxt = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: the datapath registers are reset along with control so nothing stale survives a reset.
            state      <= IDLE;
            shift_q    <= '0;
            hold_q     <= '0;
            hold_valid <= 1'b0;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            data_out   <= IDLE_LEVEL;
            frame_done <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            state      <= state_nxt;
            shift_q    <= shift_nxt;
            hold_q     <= hold_nxt;
            hold_valid <= hold_valid_nxt;
            clk_cnt    <= clk_cnt_nxt;
            bit_cnt    <= bit_cnt_nxt;
            data_out   <= data_out_nxt;
            frame_done <= frame_done_nxt;
        end
    end

endmodule

// File: tb/tb_serializer_stream.sv
// Bench for serializer_stream: three configurations checked cycle by cycle against a
// queue-of-line-samples reference model, plus directed bit-pattern checks.
module tb_serializer_stream;

    localparam int RB = 512;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic [2:0] start_v, ready_v, busy_v, dout_v, done_v;
    logic [7:0] din_v [3];

    // d0: MSB first, unframed, 1 clk/bit; d1: LSB first, unframed; d2: LSB first, framed, 4 clk/bit
    serializer_stream #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .MSB_FIRST(1'b1), .FRAMED(1'b0)) u_d0 (
        .clock(clock), .reset(reset), .data_in(din_v[0]), .start(start_v[0]),
        .ready(ready_v[0]), .busy(busy_v[0]), .data_out(dout_v[0]), .frame_done(done_v[0]));
    serializer_stream #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .MSB_FIRST(1'b0), .FRAMED(1'b0)) u_d1 (
        .clock(clock), .reset(reset), .data_in(din_v[1]), .start(start_v[1]),
        .ready(ready_v[1]), .busy(busy_v[1]), .data_out(dout_v[1]), .frame_done(done_v[1]));
    serializer_stream #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .MSB_FIRST(1'b0), .FRAMED(1'b1)) u_d2 (
        .clock(clock), .reset(reset), .data_in(din_v[2]), .start(start_v[2]),
        .ready(ready_v[2]), .busy(busy_v[2]), .data_out(dout_v[2]), .frame_done(done_v[2]));

    int errors = 0;
    int checks = 0;

    // Reference model: per DUT, a queue of upcoming line samples; frames queued counts words owned.
    logic rb_data [3][RB];
    logic rb_last [3][RB];
    int   head [3];
    int   cnt  [3];
    int   pend [3];
    logic exp_done [3];

    logic [31:0] cap [3];
    int          bc  [3];
    int          dc  [3];

    function automatic int cpb_of(input int d);
        return (d == 2) ? 4 : 1;
    endfunction

    function automatic logic msb_of(input int d);
        return (d == 0);
    endfunction

    function automatic logic framed_of(input int d);
        return (d == 2);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            head[d]     = 0;
            cnt[d]      = 0;
            pend[d]     = 0;
            exp_done[d] = 1'b0;
        end
    endtask

    task automatic clear_caps();
        for (int d = 0; d < 3; d++) begin
            cap[d] = '0;
            bc[d]  = 0;
            dc[d]  = 0;
        end
    endtask

    task automatic push(input int d, input logic b, input logic last);
        int idx;
        idx = (head[d] + cnt[d]) % RB;
        rb_data[d][idx] = b;
        rb_last[d][idx] = last;
        cnt[d]++;
    endtask

    task automatic push_frame(input int d, input logic [7:0] w);
        logic fb [10];
        int   k;
        k = 0;
        if (framed_of(d)) begin
            fb[k] = 1'b0;
            k++;
        end
        for (int i = 0; i < 8; i++) begin
            fb[k] = msb_of(d) ? w[7-i] : w[i];
            k++;
        end
        if (framed_of(d)) begin
            fb[k] = 1'b1;
            k++;
        end
        for (int j = 0; j < k; j++)
            for (int c = 0; c < cpb_of(d); c++)
                push(d, fb[j], (j == k - 1) && (c == cpb_of(d) - 1));
    endtask

    task automatic compare_all();
        logic eb, ed;
        for (int d = 0; d < 3; d++) begin
            eb = (cnt[d] > 0);
            ed = eb ? rb_data[d][head[d]] : framed_of(d);
            check($sformatf("d%0d busy", d), busy_v[d], eb);
            check($sformatf("d%0d data_out", d), dout_v[d], ed);
            check($sformatf("d%0d ready", d), ready_v[d], (pend[d] < 2));
            check($sformatf("d%0d frame_done", d), done_v[d], exp_done[d]);
            if (busy_v[d] === 1'b1) begin
                cap[d] = {cap[d][30:0], dout_v[d]};
                bc[d]++;
            end
            if (done_v[d] === 1'b1) dc[d]++;
        end
    endtask

    // Called at a falling edge with inputs already applied; advances one clock.
    task automatic tick();
        logic rdy, last;
        compare_all();
        for (int d = 0; d < 3; d++) begin
            rdy  = (pend[d] < 2);
            last = 1'b0;
            if (cnt[d] > 0) begin
                last    = rb_last[d][head[d]];
                head[d] = (head[d] + 1) % RB;
                cnt[d]--;
                if (last) pend[d]--;
            end
            exp_done[d] = last;
            if (start_v[d] && rdy) begin
                push_frame(d, din_v[d]);
                pend[d]++;
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        reset   = 1'b0;
        start_v = '0;
        for (int d = 0; d < 3; d++) din_v[d] = '0;
        model_reset();
        clear_caps();
        repeat (2) @(negedge clock);
        compare_all();
        reset = 1'b1;
        repeat (2) tick();

        // Single frames on all three configurations
        clear_caps();
        din_v[0] = 8'h9E;
        din_v[1] = 8'h9E;
        din_v[2] = 8'hA5;
        start_v  = 3'b111;
        tick();
        start_v = '0;
        repeat (44) tick();
        check("d0 msb bits", cap[0][7:0], 8'h9E);
        check("d0 busy cycles", bc[0], 8);
        check("d0 done pulses", dc[0], 1);
        check("d1 lsb bits", cap[1][7:0], 8'h79);
        check("d1 busy cycles", bc[1], 8);
        check("d2 busy cycles", bc[2], 40);
        check("d2 stop bit", cap[2][3:0], 4'hF);
        check("d2 done pulses", dc[2], 1);

        // Back-to-back with an overflow attempt while the hold is full
        clear_caps();
        din_v[0] = 8'h9E;
        start_v  = 3'b001;
        tick();
        start_v = '0;
        repeat (2) tick();
        din_v[0] = 8'h3C;
        start_v  = 3'b001;
        tick();
        check("d0 ready hold full", ready_v[0], 1'b0);
        din_v[0] = 8'hFF;
        repeat (2) tick();
        start_v = '0;
        repeat (20) tick();
        check("d0 b2b bits", cap[0][15:0], 16'h9E3C);
        check("d0 b2b busy cycles", bc[0], 16);
        check("d0 b2b done pulses", dc[0], 2);

        // Randomised traffic on all configurations
        repeat (600) begin
            for (int d = 0; d < 3; d++) begin
                start_v[d] = ($urandom_range(0, 3) == 0);
                din_v[d]   = 8'($urandom);
            end
            tick();
        end
        start_v = '0;
        repeat (50) tick();

        // Asynchronous reset in the middle of a frame
        din_v[0] = 8'h9E;
        din_v[2] = 8'hA5;
        start_v  = 3'b101;
        tick();
        start_v = '0;
        repeat (2) tick();
        #2 reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("d0 reset data_out", dout_v[0], 1'b0);
        check("d2 reset data_out", dout_v[2], 1'b1);
        @(negedge clock);
        reset = 1'b1;
        clear_caps();
        din_v[0] = 8'h55;
        start_v  = 3'b001;
        tick();
        start_v = '0;
        repeat (12) tick();
        check("d0 post-reset bits", cap[0][7:0], 8'h55);
        check("d0 post-reset busy cycles", bc[0], 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serializer_stream.md
Name: serializer_stream

Overview:
Parametrised successor to the single-shot serializer: converts a DATA_WIDTH-bit parallel word into a one-bit serial stream. Adds the following over the previous generation:
- configurable bit period
- MSB/LSB-first order
- optional start/stop framing
- a one-word holding buffer with a ready handshake, so consecutive words go out back-to-back with no idle gap

Sits between a parallel producer (controller/FIFO) and a serial line or link driver.

Parameters:
DATA_WIDTH, 8, bits per word (>=2).
CLKS_PER_BIT, 1, clock cycles each serial bit is held (>=1).
MSB_FIRST, 1, 1 = bit DATA_WIDTH-1 sent first; 0 = bit 0 sent first.
FRAMED, 0, 1 = frame is start bit (0), data bits, stop bit (1); idle line 1. 0 = data bits only; idle line 0.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset).
data_in  input  DATA_WIDTH  parallel word, sampled only on an accepting edge.
start  input  1  load request; accepted on a rising edge where start=1 and ready=1.
ready  output  1  1 = block can accept a word this cycle.
busy  output  1  1 = a frame is being shifted out.
data_out  output  1  registered serial output.
frame_done  output  1  one-cycle pulse at the end of each frame.

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately, including mid-frame): data_out = idle level (FRAMED ? 1 : 0), busy=0, ready=1, frame_done=0, holding buffer emptied, counters cleared, state IDLE. No partial frame resumes after release.
- Frame length L = DATA_WIDTH + 2*FRAMED bits; each bit lasts exactly CLKS_PER_BIT cycles; frame duration L*CLKS_PER_BIT cycles.
- States: IDLE, START_BIT (FRAMED only), DATA, STOP_BIT (FRAMED only).
- IDLE + accept at edge N:
  - word goes straight into the shift register; hold stays empty; ready stays 1.
  - after edge N: busy=1, data_out = first frame bit (start bit if FRAMED, else first data bit). Latency start->first bit = 1 edge.
- Transitions:
  - START_BIT -> DATA after CLKS_PER_BIT cycles.
  - DATA advances one bit every CLKS_PER_BIT cycles.
  - After DATA_WIDTH bits: DATA -> STOP_BIT if FRAMED, else end of frame.
  - STOP_BIT ends after CLKS_PER_BIT cycles.
- Accept while busy (hold empty): word captured into hold; ready=0 from the next cycle.
- End of frame (edge closing the final bit period), frame_done=1 for exactly that following cycle:
  - Hold full: hold moves to the shift register at that edge; next frame's first bit drives data_out immediately (zero gap); busy stays 1; ready returns to 1.
  - Hold empty: state IDLE, busy=0, data_out = idle level.
- Simultaneous end-of-frame and accept:
  - Hold empty: the new word loads directly as the next frame; no gap.
  - Hold full: ready=0, so start is ignored.
- start while ready=0: ignored; word not captured; no state change. Upstream must hold start until ready.
- Bit-period counter width: clog2(CLKS_PER_BIT) (min 1). Bit counter width: clog2(L+1). Both wrap to 0 on each new frame.
- data_in changes outside accepting edges have no effect on the frame in flight.

Test Plan:
- DATA_WIDTH=8, CLKS_PER_BIT=1, MSB_FIRST=1, FRAMED=0; data_in=8'b1001_1110, start for 1 cycle -> data_out 1,0,0,1,1,1,1,0 on 8 consecutive cycles; busy=1 for exactly 8 cycles; one frame_done pulse; data_out returns to 0.
- Same word, MSB_FIRST=0 -> data_out 0,1,1,1,1,0,0,1.
- FRAMED=1, CLKS_PER_BIT=4, MSB_FIRST=0; data_in=8'hA5 -> line idle 1; start bit 0 for 4 cycles; bits 1,0,1,0,0,1,0,1 each 4 cycles; stop bit 1 for 4 cycles; busy=1 for 40 cycles; line idles at 1.
- Back-to-back (FRAMED=0, CLKS_PER_BIT=1): send 8'h9E, then start with 8'h3C at cycle 3 of that frame -> ready=0 from the next cycle until the second frame loads; 16 contiguous bits 10011110 00111100 with no gap; two frame_done pulses 8 cycles apart; busy continuously 1 for 16 cycles.
- Overflow: with the hold full, assert start with 8'hFF -> ignored; only 8'h9E and 8'h3C appear on data_out.
- Reset mid-frame: assert reset=0 during bit 3 of 8'h9E -> outputs take reset values immediately, without waiting for a clock edge; after release, start with 8'h55 -> clean frame 0,1,0,1,0,1,0,1 (MSB_FIRST=1).
